// File: rtl/eval_sequencer.sv
// Issue sequencer for the fixed-latency move evaluator: streams one node's candidates,
// tracks in-flight slots by latency and keeps the best legal result for the search controller.
package eval_sequencer_pkg;
  typedef logic [15:0]        move_t;
  typedef logic [63:0]        board_t;
  typedef logic signed [15:0] eval_t;

  localparam eval_t EVAL_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;
endpackage

module eval_sequencer
  import eval_sequencer_pkg::*;
#(
  parameter int EVAL_LATENCY = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             cand_valid_in,
  output logic             cand_ready_out,
  input  move_t            cand_move_in,
  input  board_t           cand_board_in,
  input  logic             end_in,
  input  logic             no_validate_in,
  output logic             ev_valid_out,
  output move_t            ev_move_out,
  output board_t           ev_board_out,
  output logic             ev_no_validate_out,
  input  logic             res_valid_in,
  input  move_t            res_move_in,
  input  eval_t            res_eval_in,
  output logic             busy_out,
  output logic             result_valid_out,
  output move_t            best_move_out,
  output eval_t            best_eval_out,
  output logic             any_legal_out,
  output logic [CNT_W-1:0] legal_count_out,
  output logic             proto_err_out
);

  state_t state_q, state_d;

  logic                  accept;
  logic                  node_start;
  logic [EVAL_LATENCY:0] tok;
  logic                  due;
  logic                  others_busy;
  logic                  legal_hit;
  logic                  better;

  assign accept     = cand_valid_in && cand_ready_out;
  assign node_start = (state_q == IDLE) && start_in;

  // tok[0] is the issue strobe itself; older slots live in the shift register.
  generate
    if (EVAL_LATENCY == 0) begin : g_lat0
      assign tok         = ev_valid_out;
      assign due         = tok[0];
      assign others_busy = 1'b0;
    end else begin : g_latn
      logic [EVAL_LATENCY:1] sh_q;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          sh_q <= '0;
        end else begin
          for (int i = 1; i <= EVAL_LATENCY; i++) sh_q[i] <= tok[i-1];
        end
      end

      assign tok         = {sh_q, ev_valid_out};
      assign due         = tok[EVAL_LATENCY];
      // The due slot resolves this cycle, so only younger slots keep DRAIN open.
      assign others_busy = |tok[EVAL_LATENCY-1:0];
    end
  endgenerate

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    cand_ready_out   = 1'b0;
    result_valid_out = 1'b0;
    busy_out         = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_in) state_d = COLLECT;
      end
      COLLECT: begin
        cand_ready_out = 1'b1;
        if (end_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (!others_busy) state_d = DONE;
      end
      DONE: begin
        result_valid_out = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ev_valid_out <= 1'b0;
      ev_move_out  <= '0;
      ev_board_out <= '0;
    end else begin
      ev_valid_out <= accept;
      if (accept) begin
        ev_move_out  <= cand_move_in;
        ev_board_out <= cand_board_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)          ev_no_validate_out <= 1'b0;
    else if (node_start) ev_no_validate_out <= no_validate_in;
  end

  assign legal_hit = due && res_valid_in;
  // Strict greater-than: on a tie the earlier move stays best.
  assign better    = !any_legal_out || (res_eval_in > best_eval_out);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      best_move_out   <= '0;
      best_eval_out   <= EVAL_MIN;
      any_legal_out   <= 1'b0;
      legal_count_out <= '0;
    end else if (node_start) begin
      best_move_out   <= '0;
      best_eval_out   <= EVAL_MIN;
      any_legal_out   <= 1'b0;
      legal_count_out <= '0;
    end else if (legal_hit) begin
      if (better) begin
        best_move_out <= res_move_in;
        best_eval_out <= res_eval_in;
      end
      any_legal_out <= 1'b1;
      if (legal_count_out != '1) legal_count_out <= legal_count_out + 1'b1;
    end
  end

  // A result with no slot due is only an error while a node is actually in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      proto_err_out <= 1'b0;
    end else if (res_valid_in && !due &&
                 ((state_q == COLLECT) || (state_q == DRAIN))) begin
      proto_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eval_sequencer.sv
// Scoreboard bench for eval_sequencer: a behavioural evaluator answers issued moves after
// two cycles, stimulus queues expected node results and a monitor checks each result pulse.
module tb_eval_sequencer;
  import eval_sequencer_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in;
  logic       cand_valid_in;
  logic       cand_ready_out;
  move_t      cand_move_in;
  board_t     cand_board_in;
  logic       end_in;
  logic       no_validate_in;
  logic       ev_valid_out;
  move_t      ev_move_out;
  board_t     ev_board_out;
  logic       ev_no_validate_out;
  logic       res_valid_in;
  move_t      res_move_in;
  eval_t      res_eval_in;
  logic       busy_out;
  logic       result_valid_out;
  move_t      best_move_out;
  eval_t      best_eval_out;
  logic       any_legal_out;
  logic [7:0] legal_count_out;
  logic       proto_err_out;

  always #5 clk_in = ~clk_in;

  eval_sequencer #(.EVAL_LATENCY(2), .CNT_W(8)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .start_in           (start_in),
    .cand_valid_in      (cand_valid_in),
    .cand_ready_out     (cand_ready_out),
    .cand_move_in       (cand_move_in),
    .cand_board_in      (cand_board_in),
    .end_in             (end_in),
    .no_validate_in     (no_validate_in),
    .ev_valid_out       (ev_valid_out),
    .ev_move_out        (ev_move_out),
    .ev_board_out       (ev_board_out),
    .ev_no_validate_out (ev_no_validate_out),
    .res_valid_in       (res_valid_in),
    .res_move_in        (res_move_in),
    .res_eval_in        (res_eval_in),
    .busy_out           (busy_out),
    .result_valid_out   (result_valid_out),
    .best_move_out      (best_move_out),
    .best_eval_out      (best_eval_out),
    .any_legal_out      (any_legal_out),
    .legal_count_out    (legal_count_out),
    .proto_err_out      (proto_err_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Behavioural evaluator: moves present in eval_map are legal, everything else is illegal.
  eval_t eval_map [move_t];

  logic  p1 = 1'b0, p2 = 1'b0, l1 = 1'b0, l2 = 1'b0;
  move_t m1 = '0, m2 = '0;
  eval_t e1 = '0, e2 = '0;
  logic  inj = 1'b0;

  always @(posedge clk_in) begin
    p1 <= ev_valid_out;
    m1 <= ev_move_out;
    l1 <= eval_map.exists(ev_move_out);
    e1 <= eval_map.exists(ev_move_out) ? eval_map[ev_move_out] : eval_t'(0);
    p2 <= p1;
    m2 <= m1;
    l2 <= l1;
    e2 <= e1;
  end

  assign res_valid_in = (p2 && l2) || inj;
  assign res_move_in  = m2;
  assign res_eval_in  = e2;

  always @(posedge clk_in) cyc++;

  typedef struct {
    move_t      move;
    eval_t      eval;
    logic       any;
    logic [7:0] cnt;
    bit         chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   last_res_cyc = -100;

  // Monitor: compares each result pulse against the oldest queued expectation.
  always @(negedge clk_in) begin
    if (result_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'b0, result_valid_out}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("best_move", {16'b0, best_move_out}, {16'b0, e.move});
        check("best_eval", {16'b0, best_eval_out}, {16'b0, e.eval});
        check("any_legal", {31'b0, any_legal_out}, {31'b0, e.any});
        check("legal_count", {24'b0, legal_count_out}, {24'b0, e.cnt});
        if (e.chk_lat) check("result_latency", cyc, last_res_cyc + 1);
      end
    end
    if (res_valid_in && !inj) last_res_cyc = cyc;
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic start_node(input logic nv);
    start_in       = 1'b1;
    no_validate_in = nv;
    tick();
    start_in       = 1'b0;
    no_validate_in = 1'b0;
  endtask

  task automatic send(input move_t m, input logic last);
    cand_valid_in = 1'b1;
    cand_move_in  = m;
    cand_board_in = {48'h0, m};
    end_in        = last;
    tick();
    cand_valid_in = 1'b0;
    end_in        = 1'b0;
  endtask

  task automatic finish_node();
    end_in = 1'b1;
    tick();
    end_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 40) begin
      tick();
      n++;
    end
    check("node_completes", {31'b0, busy_out}, 32'd0);
  endtask

  task automatic expect_node(input move_t m, input eval_t e, input logic a,
                             input logic [7:0] c, input bit lat);
    exp_t x;
    x.move    = m;
    x.eval    = e;
    x.any     = a;
    x.cnt     = c;
    x.chk_lat = lat;
    exp_q.push_back(x);
  endtask

  initial begin
    rst_in         = 1'b1;
    start_in       = 1'b1;
    cand_valid_in  = 1'b0;
    cand_move_in   = '0;
    cand_board_in  = '0;
    end_in         = 1'b0;
    no_validate_in = 1'b0;

    eval_map[16'h0101] = 16'sd100;
    eval_map[16'h0102] = -16'sd50;
    eval_map[16'h0103] = 16'sd300;
    eval_map[16'h0201] = 16'sd40;
    eval_map[16'h0202] = 16'sd40;
    eval_map[16'h0301] = 16'sd500;
    eval_map[16'h0302] = 16'sd600;
    eval_map[16'h0401] = -16'sd7;

    // Reset, with start_in held high alongside it.
    repeat (3) tick();
    check("rst_busy", {31'b0, busy_out}, 32'd0);
    check("rst_ready", {31'b0, cand_ready_out}, 32'd0);
    check("rst_ev_valid", {31'b0, ev_valid_out}, 32'd0);
    check("rst_result_valid", {31'b0, result_valid_out}, 32'd0);
    check("rst_best_move", {16'b0, best_move_out}, 32'd0);
    check("rst_best_eval", {16'b0, best_eval_out}, 32'h0000_8000);
    check("rst_any_legal", {31'b0, any_legal_out}, 32'd0);
    check("rst_count", {24'b0, legal_count_out}, 32'd0);
    check("rst_proto_err", {31'b0, proto_err_out}, 32'd0);
    check("rst_no_validate", {31'b0, ev_no_validate_out}, 32'd0);
    rst_in   = 1'b0;
    start_in = 1'b0;
    tick();
    check("start_during_reset_ignored", {31'b0, busy_out}, 32'd0);

    // Three legal candidates back to back: 100, -50, 300.
    start_node(1'b0);
    check("collect_ready", {31'b0, cand_ready_out}, 32'd1);
    expect_node(16'h0103, 16'sd300, 1'b1, 8'd3, 1'b1);
    send(16'h0101, 1'b0);
    send(16'h0102, 1'b0);
    send(16'h0103, 1'b0);
    finish_node();
    wait_idle();

    // Tie at 40 keeps the first move; third is illegal and arrives with end_in.
    start_node(1'b0);
    expect_node(16'h0201, 16'sd40, 1'b1, 8'd2, 1'b0);
    send(16'h0201, 1'b0);
    send(16'h0202, 1'b0);
    send(16'h0203, 1'b1);
    wait_idle();

    // Empty node, with no_validate latched for the node.
    start_node(1'b1);
    check("no_validate_latched", {31'b0, ev_no_validate_out}, 32'd1);
    expect_node(16'h0000, 16'sh8000, 1'b0, 8'd0, 1'b0);
    finish_node();
    wait_idle();

    // Stray result in IDLE is ignored; in DRAIN with no slot it sets the sticky error.
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("proto_idle_ignored", {31'b0, proto_err_out}, 32'd0);
    start_node(1'b0);
    expect_node(16'h0000, 16'sh8000, 1'b0, 8'd0, 1'b0);
    finish_node();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("proto_drain_set", {31'b0, proto_err_out}, 32'd1);
    wait_idle();
    repeat (3) tick();
    check("proto_sticky", {31'b0, proto_err_out}, 32'd1);

    // Reset mid-COLLECT with two in flight: no pulse, late results ignored.
    start_node(1'b0);
    send(16'h0301, 1'b0);
    send(16'h0302, 1'b0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("abort_busy", {31'b0, busy_out}, 32'd0);
    repeat (4) tick();
    check("abort_late_proto", {31'b0, proto_err_out}, 32'd0);
    check("abort_late_count", {24'b0, legal_count_out}, 32'd0);
    check("abort_late_any", {31'b0, any_legal_out}, 32'd0);
    check("abort_best_eval", {16'b0, best_eval_out}, 32'h0000_8000);

    // Next node evaluates cleanly.
    start_node(1'b0);
    expect_node(16'h0401, -16'sd7, 1'b1, 8'd1, 1'b1);
    send(16'h0401, 1'b1);
    wait_idle();
    check("clean_node_proto", {31'b0, proto_err_out}, 32'd0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
